// File: rtl/sparse_weight_loader_if.sv
// Weight-SRAM read bus and dense output stream of the sparse weight loader.
// master = loader side, slave = SRAM / MAC-array side.
interface sparse_weight_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int HEADER_NUM = 8,
  parameter int NNZ_NUM    = 8,
  parameter int BLK_NUM    = 16,
  parameter int ADDR_WIDTH = 11
);
  logic [HEADER_NUM-1:0]                                w_ren;
  logic [HEADER_NUM-1:0]                                w_cs;
  logic [HEADER_NUM-1:0][ADDR_WIDTH-1:0]                w_rd_addr;
  logic [HEADER_NUM-1:0]                                w_ok;
  logic [HEADER_NUM-1:0][NNZ_NUM-1:0][DATA_WIDTH-1:0]   w;
  logic [HEADER_NUM-1:0][BLK_NUM-1:0]                   w_bit_map;
  logic                                                 dense_vld;
  logic                                                 dense_rdy;
  logic [HEADER_NUM-1:0][BLK_NUM-1:0][DATA_WIDTH-1:0]   dense_data;
  logic [ADDR_WIDTH:0]                                  dense_idx;

  modport master (
    output w_ren, w_cs, w_rd_addr, dense_vld, dense_data, dense_idx,
    input  w_ok, w, w_bit_map, dense_rdy
  );
  modport slave (
    input  w_ren, w_cs, w_rd_addr, dense_vld, dense_data, dense_idx,
    output w_ok, w, w_bit_map, dense_rdy
  );
endinterface

// File: rtl/sparse_weight_loader.sv
// Per-head sparse weight fetch + bitmap decompression into dense vectors.
// Optional WAIT watchdog: define SPARSE_WLD_TIMEOUT_EN (adds the timeout port).

module swl_head_expand #(
  parameter int DATA_WIDTH = 16,
  parameter int NNZ_NUM    = 8,
  parameter int BLK_NUM    = 16
) (
  input  logic [NNZ_NUM-1:0][DATA_WIDTH-1:0] nz,
  input  logic [BLK_NUM-1:0]                 bit_map,
  output logic [BLK_NUM-1:0][DATA_WIDTH-1:0] dense,
  output logic                               err
);
  localparam int RW = $clog2(BLK_NUM + 1);
  localparam int IW = (NNZ_NUM > 1) ? $clog2(NNZ_NUM) : 1;
  localparam logic [RW-1:0] NNZ_R = RW'(NNZ_NUM);

  logic [RW-1:0] rank;

  // rank = popcount of the bitmap below lane j, i.e. which packed value it takes
  always_comb begin
    rank  = '0;
    err   = 1'b0;
    dense = '0;
    for (int j = 0; j < BLK_NUM; j++) begin
      if (bit_map[j]) begin
        if (rank < NNZ_R) dense[j] = nz[rank[IW-1:0]];
        else              err      = 1'b1;
        rank = rank + RW'(1);
      end
    end
  end
endmodule

module sparse_weight_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int HEADER_NUM = 8,
  parameter int NNZ_NUM    = 8,
  parameter int BLK_NUM    = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [HEADER_NUM-1:0] nnz_err,
`ifdef SPARSE_WLD_TIMEOUT_EN
  output logic                  timeout,
`endif
  sparse_weight_loader_if.master bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EXP  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  typedef struct packed {
    logic [NNZ_NUM-1:0][DATA_WIDTH-1:0] nz;
    logic [BLK_NUM-1:0]                 bit_map;
  } beat_t;

  logic [2:0]                                         state;
  logic [ADDR_WIDTH-1:0]                              base_q, addr_q;
  logic [ADDR_WIDTH:0]                                len_q, idx, idx_nxt;
  logic [HEADER_NUM-1:0]                              flags, take, exp_err;
  logic                                               all_in;
  beat_t [HEADER_NUM-1:0]                             cap;
  logic [HEADER_NUM-1:0][BLK_NUM-1:0][DATA_WIDTH-1:0] exp_data, dense_q;

`ifdef SPARSE_WLD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          tmo_hit;
  assign tmo_hit = (wait_cnt == TW'(TIMEOUT - 1));
`endif

  // only the first ok per head per beat is taken; late/duplicate returns drop
  assign take    = (state == S_WAIT) ? (bus.w_ok & ~flags) : '0;
  assign all_in  = &(flags | take);
  assign idx_nxt = idx + 1'b1;

  genvar h;
  generate
    for (h = 0; h < HEADER_NUM; h++) begin : g_head
      swl_head_expand #(
        .DATA_WIDTH (DATA_WIDTH),
        .NNZ_NUM    (NNZ_NUM),
        .BLK_NUM    (BLK_NUM)
      ) u_exp (
        .nz      (cap[h].nz),
        .bit_map (cap[h].bit_map),
        .dense   (exp_data[h]),
        .err     (exp_err[h])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      idx     <= '0;
      flags   <= '0;
      cap     <= '0;
      dense_q <= '0;
      nnz_err <= '0;
`ifdef SPARSE_WLD_TIMEOUT_EN
      wait_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < HEADER_NUM; i++) begin
        if (take[i]) cap[i] <= '{nz: bus.w[i], bit_map: bus.w_bit_map[i]};
      end
      flags <= flags | take;
      case (state)
        S_IDLE: if (start) begin
          base_q  <= base_addr;
          addr_q  <= base_addr;
          len_q   <= len;
          idx     <= '0;
          nnz_err <= '0;
`ifdef SPARSE_WLD_TIMEOUT_EN
          timeout <= 1'b0;
`endif
          state   <= (len == '0) ? S_DONE : S_RD;
        end
        S_RD: begin
          flags <= '0;
`ifdef SPARSE_WLD_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (all_in) state <= S_EXP;
`ifdef SPARSE_WLD_TIMEOUT_EN
          else if (tmo_hit) begin
            timeout <= 1'b1;
            state   <= S_DONE;
          end
          wait_cnt <= wait_cnt + 1'b1;
`endif
        end
        S_EXP: begin
          dense_q <= exp_data;
          nnz_err <= nnz_err | exp_err;
          state   <= S_OUT;
        end
        S_OUT: if (bus.dense_rdy) begin
          idx <= idx_nxt;
          if (idx_nxt == len_q) state <= S_DONE;
          else begin
            addr_q <= base_q + idx_nxt[ADDR_WIDTH-1:0];
            state  <= S_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy           = (state != S_IDLE) && (state != S_DONE);
  assign done           = (state == S_DONE);
  assign bus.w_ren      = {HEADER_NUM{state == S_RD}};
  assign bus.w_cs       = {HEADER_NUM{state == S_RD}};
  assign bus.w_rd_addr  = {HEADER_NUM{addr_q}};
  assign bus.dense_vld  = (state == S_OUT);
  assign bus.dense_data = dense_q;
  assign bus.dense_idx  = idx;
endmodule

// File: tb/tb_sparse_weight_loader.sv
// Directed bench for sparse_weight_loader: SRAM responder with per-head latency,
// hand-computed dense lanes, address wrap, back-pressure and mid-run reset.
`timescale 1ns/1ps
module tb_sparse_weight_loader;
  localparam int DW = 16, HN = 8, NN = 8, BN = 16, AW = 11;
`ifdef SPARSE_WLD_TIMEOUT_EN
  localparam int TMO = 5;
`else
  localparam int TMO = 255;
`endif

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done;
  logic [HN-1:0] nnz_err;
`ifdef SPARSE_WLD_TIMEOUT_EN
  logic          timeout;
`endif

  sparse_weight_loader_if #(.DATA_WIDTH(DW), .HEADER_NUM(HN), .NNZ_NUM(NN),
                            .BLK_NUM(BN), .ADDR_WIDTH(AW)) bus ();

  sparse_weight_loader #(.DATA_WIDTH(DW), .HEADER_NUM(HN), .NNZ_NUM(NN), .BLK_NUM(BN),
                         .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .nnz_err   (nnz_err),
`ifdef SPARSE_WLD_TIMEOUT_EN
    .timeout   (timeout),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SRAM responder + monitor, all on the falling edge
  logic [HN-1:0][NN-1:0][DW-1:0] cfg_nz;
  logic [HN-1:0][BN-1:0]         cfg_bm;
  int dly [HN];
  bit resp_en = 1'b1, dup_en = 1'b0;
  int cyc = 0, ren_cyc = -1000, n_ren = 0, n_hs = 0, n_done = 0;
  logic [AW-1:0] addr_log[$];
  logic [AW:0]   idx_log[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.w_ren[0]) begin
      ren_cyc = cyc;
      n_ren++;
      addr_log.push_back(bus.w_rd_addr[0]);
    end
    if (bus.dense_vld && bus.dense_rdy) begin
      n_hs++;
      idx_log.push_back(bus.dense_idx);
    end
    if (done) n_done++;
    for (int h = 0; h < HN; h++) begin
      bus.w_ok[h]      = resp_en && (cyc == ren_cyc + dly[h]);
      bus.w[h]         = bus.w_ok[h] ? cfg_nz[h] : '0;
      bus.w_bit_map[h] = bus.w_ok[h] ? cfg_bm[h] : '0;
    end
    if (dup_en && cyc == ren_cyc + dly[0] + 1) begin
      bus.w_ok[0]      = 1'b1;
      bus.w[0]         = {NN{16'hDEAD}};
      bus.w_bit_map[0] = '1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic go(input logic [AW-1:0] b, input logic [AW:0] l);
    start = 1'b1; base_addr = b; len = l;
    tick();
    start = 1'b0;
  endtask

  // nz k of head h = {h, k+1}
  task automatic load_seq(input logic [BN-1:0] bm);
    for (int h = 0; h < HN; h++) begin
      cfg_bm[h] = bm;
      for (int k = 0; k < NN; k++) cfg_nz[h][k] = DW'((h << 8) | (k + 1));
    end
  endtask

  task automatic wait_vld(input string tag, input int budget, output int n);
    n = 0;
    while (!bus.dense_vld && n < budget) begin @(negedge clk); n++; end
    if (!bus.dense_vld) chk({tag, "_vld_tmo"}, 0, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    if (!done) chk({tag, "_done_tmo"}, 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, h0, d0, seen;
    logic [AW-1:0] exp_a [4];
    logic [DW-1:0] acc;
    exp_a = '{11'd2046, 11'd2047, 11'd0, 11'd1};
    for (int h = 0; h < HN; h++) dly[h] = 1;
    load_seq(16'hFFFF);
    bus.dense_rdy = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nnz_err", nnz_err, 0);
    chk("rst_ren", bus.w_ren, 0);
    chk("rst_cs", bus.w_cs, 0);
    chk("rst_addr", |bus.w_rd_addr, 0);
    chk("rst_vld", bus.dense_vld, 0);
    chk("rst_idx", bus.dense_idx, 0);
    chk("rst_data", |bus.dense_data, 0);
    rst = 1'b0;
    tick();

    // full bitmap, nz 1..8: exact latency from start to dense_vld and done
    bus.dense_rdy = 1'b1;
    go(11'd0, 12'd1);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_ren", bus.w_ren, 8'hFF);
    chk("t1_cs", bus.w_cs, 8'hFF);
    chk("t1_addr7", bus.w_rd_addr[7], 0);
    @(negedge clk); chk("t1_vld_k2", bus.dense_vld, 0);
    @(negedge clk); chk("t1_vld_k3", bus.dense_vld, 0);
    @(negedge clk); chk("t1_vld_k4", bus.dense_vld, 1);
    for (int h = 0; h < HN; h++)
      for (int j = 0; j < BN; j++)
        chk($sformatf("t1_h%0d_l%0d", h, j), bus.dense_data[h][j],
            (j < 8) ? ((h << 8) | (j + 1)) : 0);
    chk("t1_idx", bus.dense_idx, 0);
    chk("t1_nnz_err", nnz_err, 8'hFF);
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_busy_drop", busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    tick();

    // bitmap 8001: first and last lane only
    for (int h = 0; h < HN; h++) begin
      cfg_bm[h] = 16'h8001;
      cfg_nz[h] = {NN{16'h5555}};
      cfg_nz[h][0] = 16'hAAAA;
      cfg_nz[h][1] = 16'hBBBB;
    end
    go(11'h10, 12'd1);
    wait_vld("t2", 20, n);
    for (int h = 0; h < HN; h++) begin
      acc = '0;
      for (int j = 1; j < BN - 1; j++) acc = acc | bus.dense_data[h][j];
      chk($sformatf("t2_h%0d_l0", h), bus.dense_data[h][0], 16'hAAAA);
      chk($sformatf("t2_h%0d_l15", h), bus.dense_data[h][15], 16'hBBBB);
      chk($sformatf("t2_h%0d_mid", h), acc, 0);
    end
    chk("t2_nnz_err", nnz_err, 0);
    wait_done("t2", 20);
    tick();

    // address wrap, 4 beats
    addr_log.delete(); idx_log.delete();
    h0 = n_hs; d0 = n_done;
    go(11'd2046, 12'd4);
    wait_done("t3", 60);
    repeat (2) @(negedge clk);
    chk("t3_hs", n_hs - h0, 4);
    chk("t3_done_cnt", n_done - d0, 1);
    chk("t3_ren_cnt", addr_log.size(), 4);
    chk("t3_idx_cnt", idx_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < addr_log.size()) chk($sformatf("t3_addr%0d", i), addr_log[i], exp_a[i]);
      if (i < idx_log.size())  chk($sformatf("t3_idx%0d", i), idx_log[i], i);
    end
    tick();

    // staggered heads + duplicate ok on head 0
    load_seq(16'h00FF);
    for (int h = 0; h < HN; h++) dly[h] = 1 + h;
    dup_en = 1'b1;
    go(11'd0, 12'd1);
    @(negedge clk);
    wait_vld("t4", 30, n);
    chk("t4_vld_delay", n, 10);
    chk("t4_h0_l0", bus.dense_data[0][0], 16'h0001);
    chk("t4_h0_l7", bus.dense_data[0][7], 16'h0008);
    chk("t4_h0_l8", bus.dense_data[0][8], 0);
    chk("t4_h7_l7", bus.dense_data[7][7], 16'h0708);
    chk("t4_nnz_err", nnz_err, 0);
    wait_done("t4", 20);
    dup_en = 1'b0;
    for (int h = 0; h < HN; h++) dly[h] = 1;
    tick();

    // back-pressure: 10 cycles stalled in OUT, ignored start pulse
    load_seq(16'hFFFF);
    bus.dense_rdy = 1'b0;
    h0 = n_hs; d0 = n_done;
    go(11'd5, 12'd2);
    wait_vld("t5", 20, n);
    r0 = n_ren;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin start = 1'b1; base_addr = 11'd100; len = 12'd1; end
      if (i == 4) start = 1'b0;
      @(negedge clk);
      chk($sformatf("t5_vld%0d", i), bus.dense_vld, 1);
      chk($sformatf("t5_idx%0d", i), bus.dense_idx, 0);
      chk($sformatf("t5_data%0d", i), bus.dense_data[3][2], 16'h0303);
      chk($sformatf("t5_ren%0d", i), bus.w_ren, 0);
    end
    chk("t5_no_ren", n_ren - r0, 0);
    bus.dense_rdy = 1'b1;
    wait_done("t5", 30);
    repeat (2) @(negedge clk);
    chk("t5_ren_total", n_ren - r0, 1);
    chk("t5_hs", n_hs - h0, 2);
    chk("t5_done_cnt", n_done - d0, 1);
    tick();

    // len = 0 goes straight to DONE
    r0 = n_ren;
    go(11'd0, 12'd0);
    @(negedge clk);
    chk("t6_done", done, 1);
    chk("t6_ren", bus.w_ren, 0);
    @(negedge clk);
    chk("t6_done_pulse", done, 0);
    chk("t6_no_ren", n_ren - r0, 0);
    tick();

    // reset in WAIT of beat 2, late ok afterwards
    for (int h = 0; h < HN; h++) dly[h] = 4;
    go(11'd0, 12'd3);
    seen = 0; n = 0;
    while (seen < 2 && n < 40) begin
      @(negedge clk); n++;
      if (bus.w_ren[0]) seen++;
    end
    chk("t7_second_ren", seen, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_nnz_err", nnz_err, 0);
    chk("t7_ren", bus.w_ren, 0);
    chk("t7_addr", |bus.w_rd_addr, 0);
    chk("t7_vld", bus.dense_vld, 0);
    chk("t7_idx", bus.dense_idx, 0);
    chk("t7_data", |bus.dense_data, 0);
    rst = 1'b0;
    h0 = n_hs;
    repeat (6) @(negedge clk);
    chk("t7_late_busy", busy, 0);
    chk("t7_late_vld", bus.dense_vld, 0);
    chk("t7_late_hs", n_hs - h0, 0);
    chk("t7_late_idx", bus.dense_idx, 0);
    for (int h = 0; h < HN; h++) dly[h] = 1;

`ifdef SPARSE_WLD_TIMEOUT_EN
    // no SRAM response: abort after 5 WAIT cycles
    tick();
    resp_en = 1'b0;
    go(11'd0, 12'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t8_wait%0d_done", i), done, 0);
      chk($sformatf("t8_wait%0d_vld", i), bus.dense_vld, 0);
    end
    @(negedge clk);
    chk("t8_done", done, 1);
    chk("t8_timeout", timeout, 1);
    @(negedge clk);
    chk("t8_done_pulse", done, 0);
    chk("t8_timeout_sticky", timeout, 1);
    chk("t8_busy", busy, 0);
    resp_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sparse_weight_loader.md
# sparse_weight_loader

Per-head sparse weight fetch and decompress engine for the transformer attention datapath, parametrised in head count, data width, nonzeros per beat and block size. It walks a range of weight-SRAM addresses for all heads in lockstep, collects each head's packed nonzero values and bitmap, and expands them into one dense vector per head. It sits between the Q/K/V weight SRAMs and the per-head MAC arrays, and replaces the fixed 8-value/16-bit-bitmap read path with a buffered, back-pressured one.

## Interface
- DATA_WIDTH, 16, bits per weight element
- HEADER_NUM, 8, number of heads (SRAM channels) served in lockstep
- NNZ_NUM, 8, packed nonzero values per head per SRAM word
- BLK_NUM, 16, dense lanes per head per beat (bitmap width)
- ADDR_WIDTH, 11, SRAM word address width
- TIMEOUT, 255, WAIT-state cycle limit (used only with the macro)

- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; launches a fetch run (IDLE only)
- base_addr  in  ADDR_WIDTH  first word address, sampled on start
- len  in  ADDR_WIDTH+1  number of beats, sampled on start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at run end
- nnz_err  out  HEADER_NUM  sticky per head: bitmap popcount > NNZ_NUM; cleared on start
- w_ren, w_cs  out  HEADER_NUM  per-head SRAM read enable / chip select
- w_rd_addr  out  HEADER_NUM*ADDR_WIDTH  per-head read address (all heads equal)
- w_ok  in  HEADER_NUM  per-head read-data valid, one cycle, latency ≥1
- w  in  HEADER_NUM*NNZ_NUM*DATA_WIDTH  packed nonzeros, value 0 in LSBs
- w_bit_map  in  HEADER_NUM*BLK_NUM  bitmap, bit j = lane j nonzero
- dense_vld  out  1  dense beat valid
- dense_rdy  in  1  consumer ready
- dense_data  out  HEADER_NUM*BLK_NUM*DATA_WIDTH  expanded vectors, head 0 / lane 0 in LSBs
- dense_idx  out  ADDR_WIDTH+1  beat index within run

## Operation
- FSM: IDLE → RD → WAIT → EXP → OUT → (RD | DONE) → IDLE.
- IDLE: start with len=0 → DONE; with len>0 → RD, idx=0, nnz_err cleared. start outside IDLE is ignored.
- RD: w_ren=w_cs=all ones for exactly one cycle, w_rd_addr = (base_addr+idx) mod 2^ADDR_WIDTH; captured flags cleared.
- WAIT: a head with w_ok=1 and flag clear captures w slice and bitmap and sets its flag. Repeat ok on a flagged head is ignored. When all flags are set (including this cycle's captures) → EXP.
- EXP: per head, lane j = bit j ? nz[popcount(bitmap[j-1:0])] : 0. Ranks ≥ NNZ_NUM give 0 and set nnz_err[h]. Result is registered into dense_data.
- OUT: dense_vld=1, data/idx held stable until dense_vld&dense_rdy. Then idx+1; if idx+1==len → DONE, else → RD.
- DONE: done=1 for one cycle, busy drops the same cycle → IDLE.
- w_ok outside WAIT is ignored.

## Timing
- Reset values: all outputs 0 (busy, done, nnz_err, w_ren, w_cs, w_rd_addr, dense_vld, dense_data, dense_idx); state IDLE; flags cleared.
- Reset mid-run: immediate abort. Outstanding SRAM returns after release are ignored.
- start sampled at edge k: ren high in cycle k+1. With ok in cycle k+2, dense_vld rises in cycle k+4.
- Back-to-back: handshake at cycle m → next RD in cycle m+1; steady rate one beat per 4 cycles at 1-cycle SRAM latency with dense_rdy=1.
- Address wraps modulo 2^ADDR_WIDTH without error.
- busy rises the cycle after start.

## Configuration
- SPARSE_WLD_TIMEOUT_EN defined: a WAIT cycle counter, cleared on entering WAIT, aborts the run when it reaches TIMEOUT. The abort drives DONE, pulses done, and sets a sticky output timeout (1 bit, cleared on start, reset 0). The beat is not presented.
- Undefined: no counter and no timeout port; WAIT is held indefinitely.

## Test plan
- Reset, then start with base_addr=0, len=1, all ok one cycle after ren, bitmap=16'hFFFF, nz=1..8 → lanes 0-7 = 1..8, lanes 8-15 = 0, nnz_err=all ones; done pulses after the handshake.
- Bitmap=16'h8001, nz0=0xAAAA, nz1=0xBBBB → lane 0 = 0xAAAA, lane 15 = 0xBBBB, others 0, nnz_err=0.
- base_addr=2046, len=4 → w_rd_addr sequence 2046, 2047, 0, 1; dense_idx 0..3; exactly 4 handshakes, one done.
- Heads return ok in staggered cycles (head h at ren+1+h) plus a duplicate ok on head 0 → the duplicate is ignored; dense_vld rises only after the last head returns.
- dense_rdy held low 10 cycles in OUT → dense_data/dense_idx stable, no new ren; start pulses meanwhile are ignored.
- rst asserted during WAIT of beat 2 → all outputs 0 next cycle; a late ok is ignored. With SPARSE_WLD_TIMEOUT_EN and TIMEOUT=5 and no ok → done and timeout after 5 WAIT cycles.
